// File: rtl/bit_strobe_tx.sv
`default_nettype none
// ============================================================================
//  Module   : bit_strobe_tx
//  Purpose  : Parallel-to-serial strobe transmitter. Accepts a DATA_W-bit word
//             on a valid/ready handshake, then emits one bit per single-cycle
//             strobe (bit_en), with GAP idle cycles between strobes. Drives an
//             enable-gated capture register (data sampled when enable is high).
//  Ports    : clk       in   rising-edge clock
//             rst       in   synchronous reset, active-high
//             tx_data   in   word to send, sampled on accept
//             tx_valid  in   word available
//             tx_ready  out  word can be accepted (combinational)
//             bit_en    out  one-cycle strobe, bit_dat valid this cycle
//             bit_dat   out  serial data bit, 0 whenever bit_en is 0
//             busy      out  word in flight
//             done      out  one-cycle pulse after the last strobe of a word
//  Revision : 1.0  initial release
// ============================================================================
module bit_strobe_tx #(
    parameter int DATA_W    = 8,
    parameter int GAP       = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              bit_en,
    output logic              bit_dat,
    output logic              busy,
    output logic              done
);

    localparam int c_BW = $clog2(DATA_W + 1);
    localparam int c_GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(DATA_W - 1);
    localparam logic [c_BW-1:0] c_BIT_ONE  = c_BW'(1);
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [c_GW-1:0] c_GAP_ONE  = c_GW'(1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_STROBE = 2'd1;
    localparam logic [1:0] c_ST_WAIT   = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [c_BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [c_GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic              bit_en_q, bit_en_d;
    logic              bit_dat_q, bit_dat_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              w_accept;
    logic              w_cur_bit;

    // DONE also accepts so words can be sent back-to-back without an IDLE cycle.
    assign tx_ready = ((state_q == c_ST_IDLE) || (state_q == c_ST_DONE)) && !rst;
    assign w_accept = tx_valid && tx_ready;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= c_ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            bit_en_q  <= 1'b0;
            bit_dat_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            bit_en_q  <= bit_en_d;
            bit_dat_q <= bit_dat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_accept) state_d = c_ST_STROBE;
            end
            c_ST_STROBE: begin
                if (bit_cnt_q == c_BIT_LAST) state_d = c_ST_DONE;
                else if (GAP > 0)            state_d = c_ST_WAIT;
                else                         state_d = c_ST_STROBE;
            end
            c_ST_WAIT: begin
                if (gap_cnt_q == c_GAP_LAST) state_d = c_ST_STROBE;
            end
            c_ST_DONE: begin
                state_d = w_accept ? c_ST_STROBE : c_ST_IDLE;
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    // Shift register and counters. The shift happens in the strobe cycle, so
    // the register already presents the next bit while the gap counts down.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        if (w_accept) begin
            shift_d   = tx_data;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
        end else if (state_q == c_ST_STROBE) begin
            shift_d   = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
            bit_cnt_d = bit_cnt_q + c_BIT_ONE;
            gap_cnt_d = '0;
        end else if (state_q == c_ST_WAIT) begin
            gap_cnt_d = (gap_cnt_q == c_GAP_LAST) ? '0 : (gap_cnt_q + c_GAP_ONE);
        end
    end

    // ------------------------------------------------------------------------
    // Output logic: decoded from the next state and flopped, so every output
    // lines up with the state it describes and leaves the block glitch-free.
    // ------------------------------------------------------------------------
    assign w_cur_bit = (MSB_FIRST != 0) ? shift_d[DATA_W-1] : shift_d[0];

    always_comb begin
        bit_en_d  = (state_d == c_ST_STROBE);
        bit_dat_d = (state_d == c_ST_STROBE) && w_cur_bit;
        busy_d    = (state_d == c_ST_STROBE) || (state_d == c_ST_WAIT);
        done_d    = (state_d == c_ST_DONE);
    end

    assign bit_en  = bit_en_q;
    assign bit_dat = bit_dat_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_strobe_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bit_strobe_tx
//  Purpose  : Self-checking bench for bit_strobe_tx. Three instances cover
//             (8,2,MSB first), (8,0,LSB first) and (1,3). A timing model
//             derived from the accept cycle predicts every output each cycle;
//             an enable-gated capture register loops back instance 0.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bit_strobe_tx;

    localparam int W [3] = '{8, 8, 1};
    localparam int G [3] = '{2, 0, 3};
    localparam int M [3] = '{1, 0, 1};

    logic       clk;
    logic       rst;
    logic [7:0] td       [3];
    logic       tx_valid [3];
    logic       o_rdy    [3];
    logic       o_en     [3];
    logic       o_dat    [3];
    logic       o_busy   [3];
    logic       o_done   [3];

    int         n_checks;
    int         n_err;
    int         cyc;

    // Reference model state: one outstanding word per instance.
    bit         act     [3];
    int         acc     [3];
    logic [7:0] wrd     [3];
    bit         acc_now [3];

    logic [7:0] cap;

    bit_strobe_tx #(.DATA_W(8), .GAP(2), .MSB_FIRST(1)) u_dut0 (
        .clk(clk), .rst(rst), .tx_data(td[0]), .tx_valid(tx_valid[0]),
        .tx_ready(o_rdy[0]), .bit_en(o_en[0]), .bit_dat(o_dat[0]),
        .busy(o_busy[0]), .done(o_done[0])
    );

    bit_strobe_tx #(.DATA_W(8), .GAP(0), .MSB_FIRST(0)) u_dut1 (
        .clk(clk), .rst(rst), .tx_data(td[1]), .tx_valid(tx_valid[1]),
        .tx_ready(o_rdy[1]), .bit_en(o_en[1]), .bit_dat(o_dat[1]),
        .busy(o_busy[1]), .done(o_done[1])
    );

    bit_strobe_tx #(.DATA_W(1), .GAP(3), .MSB_FIRST(1)) u_dut2 (
        .clk(clk), .rst(rst), .tx_data(td[2][0]), .tx_valid(tx_valid[2]),
        .tx_ready(o_rdy[2]), .bit_en(o_en[2]), .bit_dat(o_dat[2]),
        .busy(o_busy[2]), .done(o_done[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Enable-gated capture register receiving instance 0 (MSB first).
    always @(posedge clk) begin
        if (o_en[0]) cap <= {cap[6:0], o_dat[0]};
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model with the
    // handshake seen at the coming edge, then return just after that edge.
    task automatic step();
        int   d, per, k;
        logic e_en, e_dat, e_busy, e_done, e_rdy;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            d      = cyc - acc[i];
            per    = (W[i] - 1) * (G[i] + 1) + 2;
            e_en   = 1'b0;
            e_dat  = 1'b0;
            e_busy = 1'b0;
            e_done = 1'b0;
            if (act[i]) begin
                if (d >= 1 && d <= per - 1) begin
                    e_busy = 1'b1;
                    if (((d - 1) % (G[i] + 1)) == 0) begin
                        k     = (d - 1) / (G[i] + 1);
                        e_en  = 1'b1;
                        e_dat = (M[i] != 0) ? wrd[i][W[i]-1-k] : wrd[i][k];
                    end
                end
                if (d == per) e_done = 1'b1;
            end
            e_rdy = !rst && (!act[i] || d >= per);
            chk($sformatf("tx_ready%0d", i), {7'b0, o_rdy[i]},  {7'b0, e_rdy});
            chk($sformatf("bit_en%0d", i),   {7'b0, o_en[i]},   {7'b0, e_en});
            chk($sformatf("bit_dat%0d", i),  {7'b0, o_dat[i]},  {7'b0, e_dat});
            chk($sformatf("busy%0d", i),     {7'b0, o_busy[i]}, {7'b0, e_busy});
            chk($sformatf("done%0d", i),     {7'b0, o_done[i]}, {7'b0, e_done});
            if (i == 0 && e_done) chk("loopback", cap, wrd[0]);

            acc_now[i] = 1'b0;
            if (rst) begin
                act[i] = 1'b0;
            end else if (tx_valid[i] && e_rdy) begin
                act[i]     = 1'b1;
                acc[i]     = cyc;
                wrd[i]     = (W[i] == 1) ? {7'b0, td[i][0]} : td[i];
                acc_now[i] = 1'b1;
            end else if (act[i] && d >= per) begin
                act[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Present a word and hold it until the model sees it accepted.
    task automatic send(input int i, input logic [7:0] w, input bit keep);
        tx_valid[i] = 1'b1;
        td[i]       = w;
        for (int n = 0; n < 64; n++) begin
            step();
            if (acc_now[i]) break;
        end
        chk($sformatf("accept%0d", i), {7'b0, acc_now[i]}, 8'h01);
        if (!keep) tx_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        for (int n = 0; n < 200; n++) begin
            if (!act[i]) break;
            step();
        end
        chk($sformatf("idle%0d", i), {7'b0, act[i]}, 8'h00);
        step();
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        cyc      = 0;
        cap      = 8'h00;
        rst      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            td[i]       = 8'h00;
            tx_valid[i] = 1'b0;
            act[i]      = 1'b0;
            acc[i]      = 0;
            wrd[i]      = 8'h00;
            acc_now[i]  = 1'b0;
        end

        // Reset state
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // MSB-first word with GAP=2
        send(0, 8'hA5, 1'b0);
        wait_idle(0);

        // Inputs churn while busy; waveform must follow the accepted word
        send(0, 8'h5A, 1'b0);
        for (int n = 0; n < 12; n++) begin
            tx_valid[0] = 1'($urandom_range(0, 1));
            td[0]       = 8'($urandom);
            step();
        end
        tx_valid[0] = 1'b0;
        wait_idle(0);

        // LSB-first, GAP=0, valid held: second word accepted in DONE
        send(1, 8'hFF, 1'b1);
        send(1, 8'h01, 1'b0);
        wait_idle(1);

        // Single-bit word with GAP=3
        send(2, 8'h01, 1'b0);
        wait_idle(2);
        send(2, 8'h00, 1'b0);
        wait_idle(2);

        // Reset during the 4th strobe aborts the word, then a clean send
        send(0, 8'h3C, 1'b0);
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (2) step();
        send(0, 8'h81, 1'b0);
        wait_idle(0);

        // Back-to-back random loopback traffic on all instances
        for (int n = 0; n < 256; n++) begin
            if (!act[1]) begin
                tx_valid[1] = 1'b1;
                td[1]       = 8'($urandom);
            end
            if (!act[2]) begin
                tx_valid[2] = 1'($urandom_range(0, 1));
                td[2]       = 8'($urandom);
            end
            send(0, 8'($urandom), (n != 255));
        end
        tx_valid[1] = 1'b0;
        tx_valid[2] = 1'b0;
        wait_idle(0);
        wait_idle(1);
        wait_idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
